// File: rtl/alu_sequencer.sv
// Fetch/execute control path between instruction memory and an external ALU.
// Optional JMP/RTN return stack is built when SEQ_RETURN_STACK_EN is defined.
module alu_sequencer #(
    parameter int unsigned SIZE        = 8,
    parameter int unsigned PC_WIDTH    = 8,
    parameter int unsigned STACK_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    output logic                imem_req,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic                imem_valid,
    input  logic [SIZE+3:0]     imem_data,
    output logic                alu_ce,
    output logic [3:0]          alu_op,
    output logic [SIZE-1:0]     alu_left,
    output logic [SIZE-1:0]     alu_right,
    output logic                alu_carry_in,
    input  logic [SIZE-1:0]     alu_result,
    input  logic                alu_carry_out,
    output logic [SIZE-1:0]     acc,
    output logic                carry_flag,
    output logic                zero_flag,
    output logic                st_valid,
    output logic [SIZE-1:0]     st_data,
    output logic                halted,
    input  logic                resume,
    output logic                stack_err
);

    typedef enum logic [1:0] {
        S_FETCH,
        S_EXEC,
        S_HALT
    } state_t;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_INC = 4'd2,
        OP_DEC = 4'd3,
        OP_AND = 4'd4,
        OP_OR  = 4'd5,
        OP_XOR = 4'd6,
        OP_NOT = 4'd7,
        OP_SHL = 4'd8,
        OP_SHR = 4'd9,
        OP_LD  = 4'd10,
        OP_ST  = 4'd11,
        OP_JMP = 4'd12,
        OP_RTN = 4'd13,
        OP_HLT = 4'd14,
        OP_NOP = 4'd15
    } opcode_t;

    state_t              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [SIZE-1:0]     acc_q, acc_d;
    logic                c_q, c_d;
    logic                z_q, z_d;
    logic [SIZE+3:0]     ir_q, ir_d;

    opcode_t             opcode;
    logic [SIZE-1:0]     imm;
    logic [PC_WIDTH-1:0] pc_inc;
    logic [PC_WIDTH-1:0] jmp_tgt;
    logic                is_alu_op;

    assign opcode    = opcode_t'(ir_q[SIZE+3:SIZE]);
    assign imm       = ir_q[SIZE-1:0];
    assign pc_inc    = pc_q + PC_WIDTH'(1);
    assign is_alu_op = (ir_q[SIZE+3:SIZE+2] != 2'b11);

    // Jump target: truncate the immediate, or zero-extend it for a wide PC.
    generate
        if (PC_WIDTH <= SIZE) begin : g_tgt_trunc
            assign jmp_tgt = imm[PC_WIDTH-1:0];
        end else begin : g_tgt_ext
            assign jmp_tgt = {{(PC_WIDTH - SIZE){1'b0}}, imm};
        end
    endgenerate

`ifdef SEQ_RETURN_STACK_EN
    localparam int unsigned AW = $clog2(STACK_DEPTH);

    logic [PC_WIDTH-1:0] stack_mem [STACK_DEPTH];
    logic [AW-1:0]       sp_q, sp_d, sp_top;
    logic                full_q, full_d;
    logic                serr_q, serr_d;
    logic                push_en;
    logic                stack_empty;

    // sp wraps to 0 when the last slot fills; full_q disambiguates full from empty.
    assign stack_empty = (sp_q == '0) && !full_q;
    assign sp_top      = sp_q - AW'(1);
    assign stack_err   = serr_q;

    always_ff @(posedge clk) begin
        if (push_en) begin
            stack_mem[sp_q] <= pc_inc;
        end
    end
`else
    assign stack_err = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        acc_d        = acc_q;
        c_d          = c_q;
        z_d          = z_q;
        ir_d         = ir_q;
        imem_req     = 1'b0;
        alu_ce       = 1'b0;
        alu_op       = '0;
        alu_left     = '0;
        alu_right    = '0;
        alu_carry_in = 1'b0;
        st_valid     = 1'b0;
        st_data      = '0;
        halted       = 1'b0;
`ifdef SEQ_RETURN_STACK_EN
        sp_d         = sp_q;
        full_d       = full_q;
        serr_d       = serr_q;
        push_en      = 1'b0;
`endif

        case (state_q)
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_valid) begin
                    ir_d    = imem_data;
                    state_d = S_EXEC;
                end
            end

            S_EXEC: begin
                state_d = S_FETCH;
                pc_d    = pc_inc;
                if (is_alu_op) begin
                    alu_ce       = 1'b1;
                    alu_op       = ir_q[SIZE+3:SIZE];
                    alu_left     = acc_q;
                    alu_right    = imm;
                    alu_carry_in = ((opcode == OP_ADD) || (opcode == OP_SUB)) ? c_q : 1'b0;
                end

                case (opcode)
                    OP_ADD, OP_SUB, OP_INC, OP_DEC, OP_SHL, OP_SHR: begin
                        acc_d = alu_result;
                        z_d   = (alu_result == '0);
                        c_d   = alu_carry_out;
                    end
                    OP_AND, OP_OR, OP_XOR, OP_NOT, OP_LD: begin
                        acc_d = alu_result;
                        z_d   = (alu_result == '0);
                    end
                    OP_ST: begin
                        st_valid = 1'b1;
                        st_data  = alu_result;
                    end
                    OP_JMP: begin
                        pc_d = jmp_tgt;
`ifdef SEQ_RETURN_STACK_EN
                        if (full_q) begin
                            serr_d = 1'b1;
                        end else begin
                            push_en = 1'b1;
                            sp_d    = sp_q + AW'(1);
                            full_d  = (sp_q == AW'(STACK_DEPTH - 1));
                        end
`endif
                    end
                    OP_RTN: begin
`ifdef SEQ_RETURN_STACK_EN
                        if (stack_empty) begin
                            serr_d = 1'b1;
                        end else begin
                            pc_d   = stack_mem[sp_top];
                            sp_d   = sp_top;
                            full_d = 1'b0;
                        end
`endif
                    end
                    OP_HLT: begin
                        state_d = S_HALT;
                    end
                    default: begin
                    end
                endcase
            end

            S_HALT: begin
                halted = 1'b1;
                if (resume) begin
                    state_d = S_FETCH;
                end
            end

            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
            pc_q    <= '0;
            acc_q   <= '0;
            c_q     <= 1'b0;
            z_q     <= 1'b0;
            ir_q    <= '0;
`ifdef SEQ_RETURN_STACK_EN
            sp_q    <= '0;
            full_q  <= 1'b0;
            serr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            acc_q   <= acc_d;
            c_q     <= c_d;
            z_q     <= z_d;
            ir_q    <= ir_d;
`ifdef SEQ_RETURN_STACK_EN
            sp_q    <= sp_d;
            full_q  <= full_d;
            serr_q  <= serr_d;
`endif
        end
    end

    assign imem_addr  = pc_q;
    assign acc        = acc_q;
    assign carry_flag = c_q;
    assign zero_flag  = z_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: a program-level reference model predicts per-fetch state.
// Honours SEQ_RETURN_STACK_EN the same way as the design build.
module tb_alu_sequencer;

    logic       clk;
    logic       rst;
    logic       imem_req;
    logic [7:0] imem_addr;
    logic       imem_valid;
    logic [11:0] imem_data;
    logic       alu_ce;
    logic [3:0] alu_op;
    logic [7:0] alu_left;
    logic [7:0] alu_right;
    logic       alu_carry_in;
    logic [7:0] alu_result;
    logic       alu_carry_out;
    logic [7:0] acc;
    logic       carry_flag;
    logic       zero_flag;
    logic       st_valid;
    logic [7:0] st_data;
    logic       halted;
    logic       resume;
    logic       stack_err;

    alu_sequencer #(.SIZE(8), .PC_WIDTH(8), .STACK_DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_valid(imem_valid), .imem_data(imem_data),
        .alu_ce(alu_ce), .alu_op(alu_op), .alu_left(alu_left), .alu_right(alu_right),
        .alu_carry_in(alu_carry_in), .alu_result(alu_result), .alu_carry_out(alu_carry_out),
        .acc(acc), .carry_flag(carry_flag), .zero_flag(zero_flag),
        .st_valid(st_valid), .st_data(st_data),
        .halted(halted), .resume(resume), .stack_err(stack_err)
    );

    typedef struct {
        logic [7:0] pc;
        logic [7:0] acc;
        logic       c;
        logic       z;
        logic       serr;
        logic       ce;
        logic [3:0] op;
        logic [7:0] left;
        logic [7:0] right;
        logic       cin;
        logic       stv;
        logic [7:0] std;
    } rec_t;

    rec_t       exp_q[$];
    logic [11:0] mem [256];
    int         vectors = 0;
    int         miscompares = 0;
    bit         mon_en = 0;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    // ALU behaviour: SUB/DEC carry is a borrow, SHL/SHR carry is the bit shifted out.
    function automatic logic [8:0] alu_ref(input logic [3:0] op, input logic [7:0] l,
                                           input logic [7:0] r, input logic cin);
        case (op)
            4'd0:  return {1'b0, l} + {1'b0, r} + {8'd0, cin};
            4'd1:  return {1'b0, l} - {1'b0, r} - {8'd0, cin};
            4'd2:  return {1'b0, l} + 9'd1;
            4'd3:  return {1'b0, l} - 9'd1;
            4'd4:  return {1'b0, l & r};
            4'd5:  return {1'b0, l | r};
            4'd6:  return {1'b0, l ^ r};
            4'd7:  return {1'b0, ~l};
            4'd8:  return {l, 1'b0};
            4'd9:  return {l[0], 1'b0, l[7:1]};
            4'd10: return {1'b0, r};
            4'd11: return {1'b0, l};
            default: return 9'd0;
        endcase
    endfunction

    always_comb begin
        {alu_carry_out, alu_result} = alu_ref(alu_op, alu_left, alu_right, alu_carry_in);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [11:0] ins(input int op, input int imm);
        logic [3:0] o;
        logic [7:0] i;
        o = op[3:0];
        i = imm[7:0];
        return {o, i};
    endfunction

    task automatic clear_mem();
        for (int a = 0; a < 256; a++) mem[a] = ins(15, 0);
    endtask

    task automatic random_mem();
        int op;
        for (int a = 0; a < 256; a++) begin
            op = $urandom_range(0, 15);
            if (op == 14 && $urandom_range(0, 3) != 0) op = 15;
            mem[a] = ins(op, $urandom_range(0, 255));
        end
    endtask

    // Program-level interpreter: pushes the state seen at each fetch plus the execute-cycle outputs.
    task automatic build_expect(input int n);
        logic [7:0] pc, a, imm;
        logic       c, z, serr;
        logic [3:0] op;
        logic [8:0] res;
        logic [7:0] stk[$];
        rec_t r;
        pc = 0; a = 0; c = 0; z = 0; serr = 0;
        for (int i = 0; i < n; i++) begin
            op  = mem[pc][11:8];
            imm = mem[pc][7:0];
            r.pc = pc; r.acc = a; r.c = c; r.z = z; r.serr = serr;
            r.ce    = (op < 12);
            r.op    = (op < 12) ? op : 4'd0;
            r.left  = (op < 12) ? a : 8'd0;
            r.right = (op < 12) ? imm : 8'd0;
            r.cin   = (op == 0 || op == 1) ? c : 1'b0;
            res     = alu_ref(op, a, imm, r.cin);
            r.stv   = (op == 11);
            r.std   = res[7:0];
            exp_q.push_back(r);
            case (op)
                0, 1, 2, 3, 8, 9: begin a = res[7:0]; z = (res[7:0] == 0); c = res[8]; pc = pc + 1; end
                4, 5, 6, 7, 10:   begin a = res[7:0]; z = (res[7:0] == 0); pc = pc + 1; end
                12: begin
`ifdef SEQ_RETURN_STACK_EN
                    if (stk.size() < 4) stk.push_back(pc + 8'd1);
                    else serr = 1;
`endif
                    pc = imm;
                end
                13: begin
`ifdef SEQ_RETURN_STACK_EN
                    if (stk.size() == 0) begin serr = 1; pc = pc + 1; end
                    else pc = stk.pop_back();
`else
                    pc = pc + 1;
`endif
                end
                default: pc = pc + 1;
            endcase
        end
    endtask

    // Monitor: each fetch handshake pops one expectation; the following cycle is its execute cycle.
    initial begin
        rec_t r;
        forever begin
            @(negedge clk);
            if (!mon_en) continue;
            if (imem_req && imem_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_fetch", imem_addr, 8'hxx);
                end else begin
                    r = exp_q.pop_front();
                    chk("fetch_pc", imem_addr, r.pc);
                    chk("acc", acc, r.acc);
                    chk("carry_flag", carry_flag, r.c);
                    chk("zero_flag", zero_flag, r.z);
                    chk("stack_err", stack_err, r.serr);
                    @(negedge clk);
                    chk("exec_alu_ce", alu_ce, r.ce);
                    chk("exec_alu_op", alu_op, r.op);
                    chk("exec_alu_left", alu_left, r.left);
                    chk("exec_alu_right", alu_right, r.right);
                    chk("exec_carry_in", alu_carry_in, r.cin);
                    chk("exec_st_valid", st_valid, r.stv);
                    if (r.stv) chk("exec_st_data", st_data, r.std);
                    chk("exec_req_low", imem_req, 0);
                end
            end else if (halted) begin
                chk("halt_req_low", imem_req, 0);
                chk("halt_alu_ce", alu_ce, 0);
            end else if (imem_req) begin
                chk("fetch_alu_ce", alu_ce, 0);
                chk("fetch_alu_lr", {alu_op, alu_left, alu_right, alu_carry_in}, 0);
                chk("fetch_st_valid", st_valid, 0);
            end
        end
    end

    // Resume driver: releases HALT after a random delay, and injects stray pulses elsewhere.
    initial begin
        resume = 0;
        forever begin
            @(posedge clk); #1;
            if (halted && !rst) begin
                resume = 0;
                repeat ($urandom_range(1, 12)) @(posedge clk);
                #1 resume = 1;
                @(posedge clk); #1 resume = 0;
            end else begin
                resume = ($urandom_range(0, 7) == 0);
            end
        end
    end

    // Called at posedge+1; grants one fetch after random stall. trail adds junk valid during execute.
    task automatic fetch_one(input bit trail);
        int t;
        logic [7:0] a, acc0;
        imem_valid = 0;
        t = 0;
        while (!imem_req && t < 400) begin
            @(posedge clk); #1;
            t++;
        end
        if (!imem_req) begin
            chk("fetch_timeout", imem_req, 1);
            return;
        end
        a = imem_addr;
        acc0 = acc;
        repeat ($urandom_range(0, 5)) begin
            @(posedge clk); #1;
            chk("stall_req", imem_req, 1);
            chk("stall_addr", imem_addr, a);
            chk("stall_acc", acc, acc0);
        end
        imem_data = mem[a];
        imem_valid = 1;
        @(posedge clk); #1;
        imem_valid = 0;
        if (trail) begin
            imem_valid = $urandom_range(0, 1);
            imem_data = 12'($urandom);
            @(posedge clk); #1;
            imem_valid = 0;
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1;
        imem_valid = 0;
        exp_q.delete();
        #2;
        chk("rst_acc", acc, 0);
        chk("rst_flags", {carry_flag, zero_flag, stack_err, halted}, 0);
        chk("rst_outs", {alu_ce, st_valid, imem_addr}, 0);
        @(posedge clk); #1;
        rst = 0;
        chk("rst_req", imem_req, 1);
        chk("rst_addr", imem_addr, 0);
    endtask

    task automatic run_phase(input int n);
        mon_en = 1;
        do_reset();
        build_expect(n);
        for (int i = 0; i < n; i++) fetch_one(1);
        repeat (3) @(posedge clk);
        #1;
        chk("queue_drained", exp_q.size(), 0);
    endtask

    initial begin
        #900000;
        miscompares++;
        $display("FAIL watchdog: simulation time expired before completion");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1);
    end

    initial begin
        rst = 1;
        imem_valid = 0;
        imem_data = 0;
        #12;

        clear_mem();
        mem[0] = ins(10, 8'h05); mem[1] = ins(2, 0); mem[2] = ins(11, 0);
        run_phase(5);

        clear_mem();
        mem[0] = ins(10, 8'hFF); mem[1] = ins(0, 8'h01); mem[2] = ins(0, 8'h00);
        run_phase(4);

        clear_mem();
        mem[3] = ins(12, 8'h20); mem[8'h20] = ins(13, 0);
        mem[4] = ins(12, 8'h30); mem[8'h30] = ins(12, 8'h40); mem[8'h40] = ins(12, 8'h50);
        mem[8'h50] = ins(12, 8'h60); mem[8'h60] = ins(12, 8'h70);
        mem[8'h70] = ins(13, 0); mem[8'h51] = ins(13, 0); mem[8'h41] = ins(13, 0);
        mem[8'h31] = ins(13, 0); mem[5] = ins(13, 0);
        run_phase(16);

        clear_mem();
        mem[7] = ins(14, 0); mem[8] = ins(10, 8'h99);
        run_phase(10);

        clear_mem();
        mem[0] = ins(12, 8'hFF);
        run_phase(3);

        // Asynchronous reset while an ADD is in its execute cycle.
        mon_en = 0;
        clear_mem();
        mem[0] = ins(10, 8'hFF); mem[1] = ins(0, 8'h01);
        mem[2] = ins(10, 8'h37); mem[3] = ins(0, 8'h01);
        do_reset();
        fetch_one(1); fetch_one(1); fetch_one(1); fetch_one(0);
        chk("pre_rst_acc", acc, 8'h37);
        chk("pre_rst_carry", carry_flag, 1);
        chk("pre_rst_addr", imem_addr, 8'h03);
        chk("pre_rst_ce", alu_ce, 1);
        #2 rst = 1;
        #1;
        chk("async_rst_acc", acc, 0);
        chk("async_rst_carry", carry_flag, 0);
        chk("async_rst_pc", imem_addr, 0);
        chk("async_rst_ce", alu_ce, 0);
        @(posedge clk); #1 rst = 0;

        for (int p = 0; p < 20; p++) begin
            random_mem();
            run_phase(60);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
